spectrum_frame_packer: RTL and testbench
========================================

SPECTRUM_FRAME_PACKER -- requirements
Module: spectrum_frame_packer

Interface
REQ-001 Parameter BINS, default 512, meaning number of bins per frame; only 512 is supported.
REQ-002 Parameter MAG_W, default 16, meaning width of the magnitude field.
REQ-003 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_mag and in_sof are valid this cycle.
REQ-006 in_sof  input  1  start of frame; marks bin 0.
REQ-007 in_mag  input  16  bin magnitude.
REQ-008 in_ready  output  1  sample is accepted this cycle when in_valid and in_ready are both high.
REQ-009 frame_out  output  25 x 512 (unpacked [511:0])  frame to the peak finder; entry k = {k[8:0], mag_k[15:0]}.
REQ-010 start  output  1  one-cycle pulse; frame_out is valid in the same cycle.
REQ-011 peak_done  input  1  consumer result pulse (the peak finder output_active); frees the bank being read.
REQ-012 sync_err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-013 frame_count  output  16  number of frames launched; wraps modulo 2^16.

Function
REQ-014 The block SHALL hold two banks, each 512 x 25 bits; each bank has a state in {EMPTY, FILLING, FULL, BUSY}.
REQ-015 Write side: wr_bank (1 bit) and wr_idx (9 bits); an accepted sample SHALL store {wr_idx, in_mag} at bank[wr_bank][wr_idx] and increment wr_idx.
REQ-016 An accepted sample with in_sof=1 SHALL be written at index 0 and set wr_idx to 1.
REQ-017 If the current bank is FILLING with wr_idx != 0 when that sof sample is accepted, the block SHALL pulse sync_err on the next cycle and discard the partial contents.
REQ-018 Samples accepted while wr_idx = 0 and no sof has been seen since reset SHALL be dropped (not written), while in_ready stays high.
REQ-019 On acceptance at wr_idx = 511: the bank SHALL go FULL, wr_bank SHALL toggle, and wr_idx SHALL wrap to 0.
REQ-020 in_ready SHALL be high exactly when bank[wr_bank] is EMPTY or FILLING; it SHALL be driven from registered state only, not from in_valid.
REQ-021 Read FSM states: IDLE and WAIT.
REQ-022 IDLE: when any bank is FULL, select it (the oldest first; on a tie, bank 0), set it BUSY, pulse start for one cycle, increment frame_count, and go to WAIT.
REQ-023 start SHALL assert no earlier than the cycle after the bank became FULL; the launch latency from the 512th accepted sample to start SHALL be 1 cycle when the read FSM is IDLE.
REQ-024 frame_out SHALL mux the selected bank and remain stable from the start cycle until peak_done.
REQ-025 The BUSY bank SHALL never be written.
REQ-026 WAIT: on peak_done, the BUSY bank SHALL go EMPTY and the FSM SHALL return to IDLE; a FULL other bank SHALL launch on the next cycle.
REQ-027 peak_done while in IDLE SHALL be ignored.
REQ-028 Simultaneous peak_done and a bank becoming FULL: both SHALL take effect in that cycle; the new launch follows 1 cycle later.
REQ-029 While both banks are FULL/BUSY, in_ready SHALL be 0; no sample is lost or overwritten.
REQ-030 Bank contents are not reset; only state, pointers, and flags are.

Reset
REQ-031 On reset, the block SHALL set: both banks EMPTY, wr_bank=0, wr_idx=0, sof-seen=0, read FSM IDLE, start=0, sync_err=0, frame_count=0, in_ready=1.
REQ-032 Reset mid-frame or during WAIT SHALL abandon all frames; a peak_done arriving after reset SHALL be ignored.

Verification
REQ-033 Reset, then 512 samples back-to-back with in_sof on the first and mag=k -> start 1 cycle after the last sample; frame_out[k]={k,k}; frame_count=1.
REQ-034 Peak finder connected, frame with mag=100 except bin 300 = 0xFFFF -> peak_index=300 and peak[15:0]=0xFFFF.
REQ-035 Stream three frames with peak_done withheld -> in_ready falls after the 1024th sample; no start for frame 2 until peak_done; frame 3 data intact.
REQ-036 Send sof after 200 samples -> sync_err pulses once; the next 512 samples form a frame with index 0 = the sof sample.
REQ-037 Send samples before any sof -> nothing stored, no start; the first sof then begins frame 0 normally.
REQ-038 Assert reset during WAIT and while 100 samples into the next frame -> outputs return to reset values next cycle; a late peak_done is ignored; frame_count=0.

Source files
------------

// File: rtl/spectrum_frame_packer_if.sv
// Sample stream in, whole-frame launch out, between the spectrum source, the packer and the peak finder.
// A sample transfers on a rising clk edge where in_valid && in_ready; in_ready depends on registered state only.
interface spectrum_frame_packer_if #(
  parameter int BINS  = 512,
  parameter int MAG_W = 16
);
  localparam int ENT_W = $clog2(BINS) + MAG_W;

  logic             in_valid;
  logic             in_sof;
  logic [MAG_W-1:0] in_mag;
  logic             in_ready;
  logic [ENT_W-1:0] frame_out [BINS-1:0];
  logic             start;
  logic             peak_done;

  modport slave (
    input  in_valid, in_sof, in_mag, peak_done,
    output in_ready, frame_out, start
  );

  modport master (
    output in_valid, in_sof, in_mag, peak_done,
    input  in_ready, frame_out, start
  );
endinterface

// File: rtl/spectrum_frame_packer.sv
// Ping-pong packer: collects BINS magnitudes into one of two banks and launches each full bank
// to the peak finder, holding it until peak_done.
module spectrum_frame_packer #(
  parameter int BINS  = 512,
  parameter int MAG_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  spectrum_frame_packer_if.slave bus,
  output logic                   sync_err,
  output logic [15:0]            frame_count,
  output logic                   dbg_rd_wait_o
);
  localparam int IDX_W = $clog2(BINS);
  localparam int ENT_W = IDX_W + MAG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_BUSY} bank_st_e;
  typedef enum logic {RD_IDLE, RD_WAIT} rd_st_e;

  bank_st_e         bst_q [2];
  bank_st_e         bst_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             sof_seen_q, sof_seen_d;
  logic             sync_err_q, sync_err_d;
  rd_st_e           rd_q, rd_d;
  logic             rd_sel_q, rd_sel_d;
  logic             start_q, start_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic [ENT_W-1:0] bank0_q [BINS];
  logic [ENT_W-1:0] bank1_q [BINS];

  logic             in_ready;
  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;

  assign in_ready = (bst_q[wr_bank_q] == B_EMPTY) || (bst_q[wr_bank_q] == B_FILLING);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    bst_d         = bst_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    sof_seen_d    = sof_seen_q;
    sync_err_d    = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wr_idx_q;
    rd_d          = rd_q;
    rd_sel_d      = rd_sel_q;
    start_d       = 1'b0;
    frame_count_d = frame_count_q;

    if (accept) begin
      if (bus.in_sof) begin
        // A sof restarts the current bank; any partial frame there is abandoned.
        sync_err_d            = (bst_q[wr_bank_q] == B_FILLING) && (wr_idx_q != '0);
        wr_en                 = 1'b1;
        wr_addr               = '0;
        wr_idx_d              = IDX_W'(1);
        sof_seen_d            = 1'b1;
        bst_d[wr_bank_q]      = B_FILLING;
      end else if (sof_seen_q) begin
        wr_en                 = 1'b1;
        wr_idx_d              = wr_idx_q + 1'b1;
        bst_d[wr_bank_q]      = B_FILLING;
        if (wr_idx_q == LAST_IDX) begin
          bst_d[wr_bank_q]    = B_FULL;
          wr_bank_d           = ~wr_bank_q;
        end
      end
    end

    // Read side only touches FULL/BUSY banks, write side only EMPTY/FILLING, so they never collide.
    case (rd_q)
      RD_IDLE: begin
        if ((bst_q[0] == B_FULL) || (bst_q[1] == B_FULL)) begin
          // With both FULL, wr_bank has toggled twice and points back at the older one.
          rd_sel_d        = ((bst_q[0] == B_FULL) && (bst_q[1] == B_FULL)) ? wr_bank_q
                                                                           : (bst_q[1] == B_FULL);
          bst_d[rd_sel_d] = B_BUSY;
          start_d         = 1'b1;
          frame_count_d   = frame_count_q + 16'd1;
          rd_d            = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.peak_done) begin
          bst_d[rd_sel_q] = B_EMPTY;
          rd_d            = RD_IDLE;
        end
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bst_q[0]      <= B_EMPTY;
      bst_q[1]      <= B_EMPTY;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      sof_seen_q    <= 1'b0;
      sync_err_q    <= 1'b0;
      rd_q          <= RD_IDLE;
      rd_sel_q      <= 1'b0;
      start_q       <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      bst_q         <= bst_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      sof_seen_q    <= sof_seen_d;
      sync_err_q    <= sync_err_d;
      rd_q          <= rd_d;
      rd_sel_q      <= rd_sel_d;
      start_q       <= start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Bank storage carries no reset; only the bookkeeping above does.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank_q) bank0_q[wr_addr] <= {wr_addr, bus.in_mag};
    if (wr_en &&  wr_bank_q) bank1_q[wr_addr] <= {wr_addr, bus.in_mag};
  end

  for (genvar k = 0; k < BINS; k++) begin : g_out
    assign bus.frame_out[k] = rd_sel_q ? bank1_q[k] : bank0_q[k];
  end

  assign bus.in_ready   = in_ready;
  assign bus.start      = start_q;
  assign sync_err       = sync_err_q;
  assign frame_count    = frame_count_q;
  assign dbg_rd_wait_o  = (rd_q == RD_WAIT);
endmodule

// File: tb/tb_spectrum_frame_packer.sv
// Directed bench for spectrum_frame_packer: framing, launch latency, back-pressure, sync errors and reset.
module tb_spectrum_frame_packer;
  logic        clk;
  logic        reset;
  logic        sync_err;
  logic [15:0] frame_count;
  logic        dbg_rd_wait;

  spectrum_frame_packer_if #(.BINS(512), .MAG_W(16)) bus ();

  spectrum_frame_packer #(.BINS(512), .MAG_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .sync_err      (sync_err),
    .frame_count   (frame_count),
    .dbg_rd_wait_o (dbg_rd_wait)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          start_cnt = 0;
  int          serr_cnt = 0;
  logic [24:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.start) start_cnt++;
    if (sync_err)  serr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat_mag(input int pat, input int k);
    case (pat)
      0:       return 16'(k);
      1:       return (k == 300) ? 16'hFFFF : 16'd100;
      default: return 16'(pat * 257 + k * 3);
    endcase
  endfunction

  // driver tasks
  task automatic send(input logic sof, input logic [15:0] mag);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_mag   = mag;
    while (!bus.in_ready && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 4000) chk("ready_timeout", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int pat);
    for (int k = 0; k < 512; k++) send(k == 0, pat_mag(pat, k));
  endtask

  task automatic pulse_done();
    bus.peak_done = 1'b1;
    @(posedge clk); #1;
    bus.peak_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.start && n < 50);
    chk(tag, 32'(bus.start), 1);
  endtask

  // scoreboard
  task automatic expect_frame(input int pat);
    for (int k = 0; k < 512; k++) exp_q.push_back({9'(k), pat_mag(pat, k)});
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < 512; k++) chk(tag, 32'(bus.frame_out[k]), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int          s0;
    int          e0;
    int          pk_idx;
    logic [15:0] pk_mag;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_mag    = 16'd0;
    bus.peak_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_rd_state", 32'(dbg_rd_wait), 0);

    // samples before any sof are dropped
    for (int i = 0; i < 5; i++) send(1'b0, 16'hDEAD);
    chk("drop_in_ready", 32'(bus.in_ready), 1);
    repeat (3) @(posedge clk); #1;
    chk("drop_no_start", 32'(start_cnt), 0);

    // first frame, launch latency and contents
    send_frame(0);
    chk("lat_start_early", 32'(bus.start), 0);
    @(posedge clk); #1;
    chk("lat_start", 32'(bus.start), 1);
    chk("fc_1", 32'(frame_count), 1);
    chk("rd_wait_1", 32'(dbg_rd_wait), 1);
    expect_frame(0);
    check_frame("f0_data");
    chk("f0_no_serr", 32'(serr_cnt), 0);
    @(posedge clk); #1;
    chk("start_pulse", 32'(bus.start), 0);
    pulse_done();
    chk("done_to_idle", 32'(dbg_rd_wait), 0);
    pulse_done();
    repeat (2) @(posedge clk); #1;
    chk("idle_done_fc", 32'(frame_count), 1);
    chk("idle_done_state", 32'(dbg_rd_wait), 0);

    // peak frame: bin 300 carries the maximum
    send_frame(1);
    wait_start("f1_start");
    chk("fc_2", 32'(frame_count), 2);
    pk_idx = 0;
    pk_mag = 16'd0;
    for (int k = 0; k < 512; k++) begin
      if (bus.frame_out[k][15:0] > pk_mag) begin
        pk_mag = bus.frame_out[k][15:0];
        pk_idx = int'(bus.frame_out[k][24:16]);
      end
    end
    chk("peak_index", 32'(pk_idx), 300);
    chk("peak_mag", 32'(pk_mag), 32'h0000_FFFF);
    pulse_done();

    // three frames with peak_done withheld
    s0 = start_cnt;
    send_frame(2);
    send_frame(3);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    repeat (5) @(posedge clk); #1;
    chk("one_launch", 32'(start_cnt - s0), 1);
    chk("fc_3", 32'(frame_count), 3);
    fork
      send_frame(4);
      begin
        repeat (20) @(posedge clk); #1;
        chk("held_in_ready", 32'(bus.in_ready), 0);
        chk("held_no_start", 32'(start_cnt - s0), 1);
        pulse_done();
        wait_start("f3_start");
        chk("fc_4", 32'(frame_count), 4);
        expect_frame(3);
        check_frame("f3_data");
      end
    join
    chk("full2_in_ready", 32'(bus.in_ready), 0);
    chk("rd_wait_f3", 32'(dbg_rd_wait), 1);
    pulse_done();
    wait_start("f4_start");
    chk("fc_5", 32'(frame_count), 5);
    expect_frame(4);
    check_frame("f4_data");
    pulse_done();

    // sof after 200 samples restarts the frame
    e0 = serr_cnt;
    send(1'b1, 16'h1111);
    for (int i = 1; i < 200; i++) send(1'b0, 16'(i));
    send(1'b1, pat_mag(5, 0));
    chk("serr_pulse", 32'(sync_err), 1);
    for (int k = 1; k < 512; k++) send(1'b0, pat_mag(5, k));
    wait_start("f5_start");
    chk("serr_once", 32'(serr_cnt - e0), 1);
    chk("fc_6", 32'(frame_count), 6);
    expect_frame(5);
    check_frame("f5_data");

    // reset while in WAIT and 100 samples into the next frame
    send(1'b1, pat_mag(6, 0));
    for (int k = 1; k < 100; k++) send(1'b0, pat_mag(6, k));
    chk("pre_rst_wait", 32'(dbg_rd_wait), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2_in_ready", 32'(bus.in_ready), 1);
    chk("rst2_start", 32'(bus.start), 0);
    chk("rst2_sync_err", 32'(sync_err), 0);
    chk("rst2_frame_count", 32'(frame_count), 0);
    chk("rst2_rd_state", 32'(dbg_rd_wait), 0);
    reset = 1'b0;
    s0 = start_cnt;
    pulse_done();
    repeat (3) @(posedge clk); #1;
    chk("late_done_state", 32'(dbg_rd_wait), 0);
    chk("late_done_nostart", 32'(start_cnt - s0), 0);
    chk("late_done_fc", 32'(frame_count), 0);
    send_frame(7);
    wait_start("f7_start");
    chk("fc_after_rst", 32'(frame_count), 1);
    expect_frame(7);
    check_frame("f7_data");
    pulse_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
